// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst address generator.
// Accepts one AW/AR-style command per burst and emits one beat descriptor
// (address, byte strobe, index, last, error) per data transfer. Covers
// FIXED, INCR and WRAP bursts for any power-of-two DATA_WIDTH.
// Optional feature: define AXI4_BURST_ERR_CHECK_EN to build the burst
// legality checker; otherwise beat_err is tied to 0.

module axi4_burst_addr_gen #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int ID_WIDTH      = 4,
   parameter int LEN_WIDTH     = 8
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [ID_WIDTH-1:0]        cmd_id,
   input  logic [ADDRESS_WIDTH-1:0]   cmd_addr,
   input  logic [LEN_WIDTH-1:0]       cmd_len,
   input  logic [2:0]                 cmd_size,
   input  logic [1:0]                 cmd_burst,
   output logic                       beat_valid,
   input  logic                       beat_ready,
   output logic [ID_WIDTH-1:0]        beat_id,
   output logic [ADDRESS_WIDTH-1:0]   beat_addr,
   output logic [DATA_WIDTH/8-1:0]    beat_strb,
   output logic [LEN_WIDTH-1:0]       beat_idx,
   output logic                       beat_last,
   output logic                       beat_err,
   output logic                       busy
);

   localparam int STRB_W     = DATA_WIDTH / 8;
   localparam int SIZE_MAX_I = $clog2(STRB_W);
   localparam logic [2:0] SIZE_MAX = 3'(SIZE_MAX_I);
   localparam logic [ADDRESS_WIDTH-1:0] ONE       = ADDRESS_WIDTH'(1);
   localparam logic [ADDRESS_WIDTH-1:0] LANE_MASK = ADDRESS_WIDTH'(STRB_W - 1);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   // ST_INIT keeps cmd_ready low for the first edge after reset release.
   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // Wrap window in bytes: beats rounded up to a power of two, times beat size.
   // Legal WRAP lengths (2/4/8/16 beats) are already powers of two.
   function automatic logic [ADDRESS_WIDTH-1:0] wrap_span(
      input logic [LEN_WIDTH-1:0] len,
      input logic [2:0]           esize
   );
      logic [LEN_WIDTH:0] beats;
      logic [LEN_WIDTH:0] pow;
      beats = {1'b0, len} + (LEN_WIDTH+1)'(1);
      pow   = (LEN_WIDTH+1)'(1);
      // Walk downwards so the smallest power >= beats is the one kept.
      for (int i = LEN_WIDTH; i >= 0; i--) begin
         if (beats <= ((LEN_WIDTH+1)'(1) << i)) begin
            pow = (LEN_WIDTH+1)'(1) << i;
         end
      end
      return ADDRESS_WIDTH'(pow) << esize;
   endfunction

   state_t                     state_q, state_d;
   logic [ID_WIDTH-1:0]        id_q, id_d;
   logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
   logic [ADDRESS_WIDTH-1:0]   lower_q, lower_d;
   logic [ADDRESS_WIDTH-1:0]   span_q, span_d;
   logic [LEN_WIDTH-1:0]       len_q, len_d;
   logic [LEN_WIDTH-1:0]       idx_q, idx_d;
   logic [2:0]                 size_q, size_d;
   logic [1:0]                 burst_q, burst_d;

   logic                       cmd_hs;
   logic                       run;
   logic [2:0]                 cmd_esize;
   logic [ADDRESS_WIDTH-1:0]   cmd_bytes;
   logic [ADDRESS_WIDTH-1:0]   cmd_span;
   logic [ADDRESS_WIDTH-1:0]   cmd_lower;

   logic [ADDRESS_WIDTH-1:0]   bytes;
   logic [ADDRESS_WIDTH-1:0]   aligned;
   logic [ADDRESS_WIDTH-1:0]   step;
   logic [ADDRESS_WIDTH-1:0]   next_addr;
   logic                       last;
   logic [ADDRESS_WIDTH-1:0]   lane_lo;
   logic [ADDRESS_WIDTH-1:0]   lane_hi;

   assign run    = (state_q == ST_RUN);
   assign cmd_hs = cmd_valid && (state_q == ST_IDLE);

   // Command-side decode: clamp the size and derive the wrap window.
   always_comb begin
      cmd_esize = (cmd_size > SIZE_MAX) ? SIZE_MAX : cmd_size;
      cmd_bytes = ONE << cmd_esize;
      cmd_span  = wrap_span(cmd_len, cmd_esize);
      cmd_lower = cmd_addr & ~(cmd_span - ONE);
   end

   // Beat-side arithmetic: next address for the latched burst type.
   always_comb begin
      bytes   = ONE << size_q;
      aligned = addr_q & ~(bytes - ONE);
      step    = aligned + bytes;
      last    = (idx_q == len_q);
      case (burst_q)
         BURST_INCR: next_addr = step;
         BURST_WRAP: next_addr = (step == lower_q + span_q) ? lower_q : step;
         default:    next_addr = addr_q;   // FIXED and RESERVED hold the start address
      endcase
   end

   // Next-state and handshake outputs.
   // NOTE: every signal assigned here gets a default first so no path leaves
   // it unassigned; otherwise synthesis would infer a latch to hold it.
   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      addr_d     = addr_q;
      lower_d    = lower_q;
      span_d     = span_q;
      len_d      = len_q;
      idx_d      = idx_q;
      size_d     = size_q;
      burst_d    = burst_q;
      cmd_ready  = 1'b0;
      beat_valid = 1'b0;
      case (state_q)
         ST_INIT: begin
            state_d = ST_IDLE;
         end
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_hs) begin
               id_d    = cmd_id;
               addr_d  = cmd_addr;
               lower_d = cmd_lower;
               span_d  = cmd_span;
               len_d   = cmd_len;
               size_d  = cmd_esize;
               burst_d = cmd_burst;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            beat_valid = 1'b1;
            if (beat_ready) begin
               if (last) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d  = idx_q + LEN_WIDTH'(1);
                  addr_d = next_addr;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and burst-context registers; reset parks the block in ST_INIT.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= ST_INIT;
         id_q    <= '0;
         addr_q  <= '0;
         lower_q <= '0;
         span_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         size_q  <= '0;
         burst_q <= BURST_FIXED;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         lower_q <= lower_d;
         span_q  <= span_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         size_q  <= size_d;
         burst_q <= burst_d;
      end
   end

   // Strobe: lanes from the (possibly unaligned) beat address up to the end
   // of its aligned beat window.
   always_comb begin
      lane_lo   = addr_q & LANE_MASK;
      lane_hi   = (aligned & LANE_MASK) + bytes - ONE;
      beat_strb = '0;
      for (int k = 0; k < STRB_W; k++) begin
         beat_strb[k] = run && (ADDRESS_WIDTH'(k) >= lane_lo) && (ADDRESS_WIDTH'(k) <= lane_hi);
      end
   end

   assign beat_id   = id_q;
   assign beat_addr = addr_q;
   assign beat_idx  = idx_q;
   assign beat_last = run && last;
   assign busy      = run;

`ifdef AXI4_BURST_ERR_CHECK_EN
   logic                     err_q, err_d;
   logic                     cmd_err;
   logic                     wrap_len_ok;
   logic [ADDRESS_WIDTH-1:0] incr_last_addr;

   // Legality checks evaluated on the command as presented.
   always_comb begin
      wrap_len_ok    = (cmd_len == LEN_WIDTH'(1)) || (cmd_len == LEN_WIDTH'(3)) ||
                       (cmd_len == LEN_WIDTH'(7)) || (cmd_len == LEN_WIDTH'(15));
      incr_last_addr = (cmd_addr & ~(cmd_bytes - ONE)) + (ADDRESS_WIDTH'(cmd_len) << cmd_esize);
      cmd_err        = (cmd_burst == BURST_RSVD) ||
                       (cmd_size > SIZE_MAX) ||
                       ((cmd_burst == BURST_WRAP) &&
                        (!wrap_len_ok || ((cmd_addr & (cmd_bytes - ONE)) != '0))) ||
                       ((cmd_burst == BURST_INCR) &&
                        (cmd_addr[ADDRESS_WIDTH-1:12] != incr_last_addr[ADDRESS_WIDTH-1:12]));
      err_d          = cmd_hs ? cmd_err : err_q;
   end

   // Error flag latched with the rest of the burst context.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign beat_err = run && err_q;
`else
   assign beat_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Self-checking bench for axi4_burst_addr_gen (DATA_WIDTH=32).
// Directed scenarios plus randomized bursts compared against a behavioural
// model that derives every beat directly from its index.

module tb_axi4_burst_addr_gen;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int LW = 8;
   localparam int SW = DW / 8;

   logic          aclk = 1'b0;
   logic          areset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [IW-1:0] cmd_id;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_len;
   logic [2:0]    cmd_size;
   logic [1:0]    cmd_burst;
   logic          beat_valid;
   logic          beat_ready;
   logic [IW-1:0] beat_id;
   logic [AW-1:0] beat_addr;
   logic [SW-1:0] beat_strb;
   logic [LW-1:0] beat_idx;
   logic          beat_last;
   logic          beat_err;
   logic          busy;

   always #5 aclk = ~aclk;

   axi4_burst_addr_gen #(
      .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)
   ) dut (
      .aclk(aclk), .areset(areset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
      .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id),
      .beat_addr(beat_addr), .beat_strb(beat_strb), .beat_idx(beat_idx),
      .beat_last(beat_last), .beat_err(beat_err), .busy(busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic [SW-1:0] strb;
      logic [LW-1:0] idx;
      logic          last;
      logic          err;
   } beat_t;

   beat_t         exp_q[$];
   logic [AW-1:0] got_addr[$];
   logic [SW-1:0] got_strb[$];
   int            burst_cycles;

   // Reference model: each beat's address is computed directly from its index.
   function automatic void build_model(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
      int            esize;
      int            beats;
      int            span;
      logic [AW-1:0] bytes, aligned0, wb, lower, a, last_a;
      logic          err;
      beat_t         b;
      exp_q.delete();
      esize    = (size > 3'd2) ? 2 : int'(size);
      bytes    = 32'd1 << esize;
      aligned0 = addr & ~(bytes - 32'd1);
      beats    = 1;
      while (beats < int'(len) + 1) beats = beats * 2;
      wb       = bytes * 32'(beats);
      lower    = addr & ~(wb - 32'd1);
`ifdef AXI4_BURST_ERR_CHECK_EN
      last_a = aligned0 + 32'(len) * bytes;
      err = (burst == 2'b11) || (size > 3'd2) ||
            ((burst == 2'b10) && (!(len == 1 || len == 3 || len == 7 || len == 15) ||
                                  ((addr & (bytes - 32'd1)) != 0))) ||
            ((burst == 2'b01) && ((addr >> 12) != (last_a >> 12)));
`else
      last_a = '0;
      err    = 1'b0;
`endif
      for (int n = 0; n <= int'(len); n++) begin
         if (burst == 2'b01)
            a = (n == 0) ? addr : aligned0 + 32'(n) * bytes;
         else if (burst == 2'b10)
            a = (n == 0) ? addr : lower + ((aligned0 - lower + 32'(n) * bytes) % wb);
         else
            a = addr;
         span   = int'(((a & ~(bytes - 32'd1)) + bytes) - a);
         b.strb = '0;
         for (int j = 0; j < span; j++) b.strb[(a + 32'(j)) % SW] = 1'b1;
         b.addr = a;
         b.idx  = LW'(n);
         b.last = (n == int'(len));
         b.err  = err;
         exp_q.push_back(b);
      end
   endfunction

   // Entered and left on a falling edge. abort_idx >= 0 returns right after
   // that beat's handshake, leaving the rest of the burst outstanding.
   task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [LW-1:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int stall_pct,
                            input int stall_idx, input int stall_cycles, input int abort_idx);
      beat_t       e;
      int          cyc;
      int          stalled;
      logic        ready;
      logic        held;
      logic [63:0] snap;
      build_model(addr, len, size, burst);
      got_addr.delete();
      got_strb.delete();
      cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
      cmd_valid = 1'b1;
      cyc = 0;
      while (!cmd_ready && cyc < 50) begin
         @(negedge aclk);
         cyc++;
      end
      if (!cmd_ready) begin
         check("cmd_accept_timeout", 64'd0, 64'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(negedge aclk);
      // Scramble the command bus: it must be ignored outside the handshake.
      cmd_valid = 1'b0;
      cmd_id = IW'($urandom); cmd_addr = $urandom; cmd_len = LW'($urandom);
      cmd_size = 3'($urandom); cmd_burst = 2'($urandom);
      check("first_beat_latency", 64'(beat_valid), 64'd1);
      check("busy_in_burst", 64'(busy), 64'd1);
      cyc = 0; stalled = 0; held = 1'b0; snap = '0;
      while (exp_q.size() > 0 && cyc < 300) begin
         if (held)
            check("stall_hold", {beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_err}, snap);
         if (!beat_valid) begin
            check("valid_dropped", 64'(beat_valid), 64'd1);
            break;
         end
         if (int'(beat_idx) == stall_idx && stalled < stall_cycles) begin
            ready = 1'b0;
            stalled++;
         end else begin
            ready = ($urandom_range(0, 99) >= 32'(stall_pct));
         end
         beat_ready = ready;
         held = !ready;
         snap = {beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_err};
         if (ready) begin
            e = exp_q.pop_front();
            check("beat_addr", 64'(beat_addr), 64'(e.addr));
            check("beat_strb", 64'(beat_strb), 64'(e.strb));
            check("beat_idx",  64'(beat_idx),  64'(e.idx));
            check("beat_last", 64'(beat_last), 64'(e.last));
            check("beat_err",  64'(beat_err),  64'(e.err));
            check("beat_id",   64'(beat_id),   64'(id));
            got_addr.push_back(beat_addr);
            got_strb.push_back(beat_strb);
            if (int'(e.idx) == abort_idx) begin
               @(negedge aclk);
               beat_ready = 1'b0;
               return;
            end
         end
         @(negedge aclk);
         cyc++;
      end
      beat_ready   = 1'b0;
      burst_cycles = cyc;
      if (exp_q.size() != 0) check("burst_incomplete", 64'(exp_q.size()), 64'd0);
      check("gap_cmd_ready", 64'(cmd_ready), 64'd1);
      check("gap_bubble", 64'(beat_valid), 64'd0);
   endtask

   initial begin
      logic [AW-1:0] r_addr;
      logic [LW-1:0] r_len;
      logic [2:0]    r_size;
      logic [1:0]    r_burst;
      areset = 1'b1; cmd_valid = 1'b0; beat_ready = 1'b0;
      cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
      repeat (3) @(negedge aclk);
      check("rst_cmd_ready",  64'(cmd_ready),  64'd0);
      check("rst_beat_valid", 64'(beat_valid), 64'd0);
      check("rst_outputs", {beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_err, busy}, 64'd0);
      areset = 1'b0;
      #1 check("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
      @(negedge aclk);
      check("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

      // INCR unaligned start.
      run_burst(4'h3, 32'h1002, 8'd3, 3'd2, 2'b01, 0, -1, 0, -1);
      check("incr_a0", 64'(got_addr[0]), 64'h1002);
      check("incr_a3", 64'(got_addr[3]), 64'h100C);
      check("incr_s0", 64'(got_strb[0]), 64'hC);
      check("incr_s1", 64'(got_strb[1]), 64'hF);

      // WRAP within a 16-byte window.
      run_burst(4'h5, 32'h0034, 8'd3, 3'd2, 2'b10, 0, -1, 0, -1);
      check("wrap_a2", 64'(got_addr[2]), 64'h3C);
      check("wrap_a3", 64'(got_addr[3]), 64'h30);

      // FIXED byte burst, then a back-to-back single-beat INCR.
      run_burst(4'h9, 32'h0101, 8'd2, 3'd0, 2'b00, 0, -1, 0, -1);
      check("fixed_a2", 64'(got_addr[2]), 64'h101);
      check("fixed_s2", 64'(got_strb[2]), 64'h2);
      run_burst(4'h1, 32'h0000, 8'd0, 3'd2, 2'b01, 0, -1, 0, -1);

      // Five-cycle backpressure on beat 1.
      run_burst(4'h2, 32'h0000, 8'd3, 3'd2, 2'b01, 0, 1, 5, -1);
      check("stall_duration", 64'(burst_cycles), 64'd9);

      // INCR crossing a 4 KB boundary.
      run_burst(4'h7, 32'h0FF8, 8'd3, 3'd2, 2'b01, 0, -1, 0, -1);
      check("cross_a3", 64'(got_addr[3]), 64'h1004);

      // Reset mid-burst after beat 2.
      run_burst(4'hA, 32'h0200, 8'd7, 3'd2, 2'b01, 0, -1, 0, 2);
      areset = 1'b1;
      #1;
      check("midrst_valid", 64'(beat_valid), 64'd0);
      check("midrst_ready", 64'(cmd_ready), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      repeat (2) @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
      run_burst(4'hB, 32'h0300, 8'd7, 3'd2, 2'b01, 0, -1, 0, -1);
      check("post_rst_a0", 64'(got_addr[0]), 64'h300);

      // Randomized bursts with random backpressure.
      for (int t = 0; t < 200; t++) begin
         r_burst = 2'($urandom_range(0, 3));
         r_size  = 3'($urandom_range(0, 3));
         if (r_burst == 2'b10 && $urandom_range(0, 3) != 0)
            r_len = LW'((2 << $urandom_range(0, 3)) - 1);
         else
            r_len = LW'($urandom_range(0, 20));
         if ($urandom_range(0, 4) == 0)
            r_addr = 32'hFFFF_FFC0 | 32'($urandom_range(0, 63));
         else if ($urandom_range(0, 3) == 0)
            r_addr = 32'h0000_0FC0 | 32'($urandom_range(0, 63));
         else
            r_addr = $urandom;
         run_burst(IW'($urandom), r_addr, r_len, r_size, r_burst,
                   ($urandom_range(0, 1) == 0) ? 0 : 40, -1, 0, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
